turbo_rx_pb_loader: RTL
=======================

Name: turbo_rx_pb_loader

Overview:
- Upstream fill stage for the turbo RX deinterleaver.
- Accepts a stream of 2-bit soft symbols with valid/ready, one physical block (PB) at a time.
- Writes each symbol into the deinterleaver RAM at pb_offset + index.
- Once the PB is complete, issues a one-cycle start with pb_len, pb_offset and mode held stable, then back-pressures the source until the reader has drained.

Parameters:
- D_WIDTH, 2, symbol width (wdata/din).
- A_WIDTH, 12, RAM address width.
- DRAIN_LAT, 3, extra cycles waited after the reader's pb_len read cycles before accepting a new PB.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- din  in  D_WIDTH  input symbol
- din_vld  in  1  symbol valid
- din_sof  in  1  first symbol of a PB; qualified by din_vld
- din_rdy  out  1  loader can accept a symbol this cycle
- pb_size_sel  in  2  PB size, sampled at SOF: 00 = 16 B (0x040), 01 = 136 B (0x220), 10 = 520 B (0x820), 11 = illegal
- pb_base  in  A_WIDTH  RAM base address, sampled at SOF
- mode_in  in  1  int/dint select, sampled at SOF
- wen  out  1  RAM write enable
- waddr  out  A_WIDTH  RAM write address
- wdata  out  D_WIDTH  RAM write data
- pb_len  out  A_WIDTH  latched PB length in symbols
- pb_offset  out  A_WIDTH  latched base address
- mod_int_dint  out  1  latched mode
- start  out  1  one-cycle read-start pulse to the deinterleaver
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset values: all outputs 0 except din_rdy = 1; state = IDLE; counters = 0.
- Accept condition: a symbol is accepted when din_vld && din_rdy.
- Write port timing: wen/waddr/wdata are registered, one cycle after acceptance.
  - waddr = pb_offset + cnt, modulo 2^A_WIDTH (wrap allowed, no error).
- States:
  - IDLE: din_rdy = 1.
    - Accepted din_sof with legal size: latch pb_len, pb_offset, mod_int_dint; write symbol at index 0; cnt = 1; go to FILL.
    - Accepted symbol without din_sof: dropped, err pulse.
    - din_sof with pb_size_sel = 11: dropped, err pulse, stay in IDLE.
  - FILL: din_rdy = 1.
    - Each accepted symbol is written at index cnt, then cnt increments.
    - The accept with cnt == pb_len-1 goes to START.
    - din_sof in FILL: abort the current PB, err pulse, treat the symbol as the SOF of a new PB (same rules as IDLE, including the illegal-size case, which returns to IDLE).
  - START: din_rdy = 0.
    - start = 1 for exactly one cycle, asserted in the cycle after the last wen.
    - pb_len, pb_offset and mod_int_dint are already stable.
    - Next state: DRAIN, with drain_cnt = 0.
  - DRAIN: din_rdy = 0; drain_cnt increments each cycle.
    - Go to IDLE when drain_cnt == pb_len + DRAIN_LAT - 1.
    - Latched pb_len, pb_offset and mod_int_dint hold until the next SOF.
- Gaps: din_vld may drop at any time in FILL with no timeout; din_sof without din_vld is ignored.
- Reset mid-operation returns to IDLE immediately; the partial PB is discarded and start is not issued.
- The symbol counter is A_WIDTH wide; drain_cnt is A_WIDTH+1 wide.

Optional Feature:
- Macro: TURBO_LOADER_ERR_CNT_EN.
- With the macro: adds output err_cnt[7:0], a saturating count of err pulses (holds at 0xFF), cleared only by reset.
- Without the macro: the port and counter are absent; err behaviour is unchanged.

Decomposition:
- Shared package (turbo_pkg):
  - PB length constants PB_LEN_16 = 12'h040, PB_LEN_136 = 12'h220, PB_LEN_520 = 12'h820.
  - pb_size_sel encodings.
  - Loader state enum (IDLE, FILL, START, DRAIN).
- Sub-module: turbo_pb_len_dec, a combinational decode from pb_size_sel to pb_len plus an illegal flag. It is reused by the TX side.

Test Plan:
- Nominal fill, 16 B: pb_size_sel = 00, pb_base = 0x100, 64 symbols with no gaps -> 64 wen at waddr 0x100..0x13F; start one cycle after the last wen with pb_len = 0x040; din_rdy low for 1 + 64 + 3 cycles.
- Gaps and wrap: pb_size_sel = 01, pb_base = 0xF00, din_vld toggling 1/0 -> 0x220 writes; waddr wraps 0xFFF -> 0x000 and ends at 0x11F; a single start pulse.
- Restart: SOF mid-fill after 10 symbols of a 520 B PB -> err pulse; the next write goes to pb_base index 0 of the new PB; the following full PB issues start with pb_len = 0x820.
- Protocol errors:
  - Stray din_vld in IDLE without SOF -> err pulse, no wen.
  - SOF with pb_size_sel = 11 -> err pulse, remains in IDLE.
- Back-pressure: drive din_vld during DRAIN -> no wen and no counter change; the first accept after return to IDLE must carry SOF.
- Reset mid-FILL (after 5 symbols) -> all outputs return to reset values with no start; TURBO_LOADER_ERR_CNT_EN build: 300 errors -> err_cnt = 0xFF.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared turbo definitions: PB length constants, size-select encodings and
// the RX loader state enum.
package turbo_pkg;

    localparam int PB_LEN_W = 12;

    localparam logic [PB_LEN_W-1:0] PB_LEN_16  = 12'h040;
    localparam logic [PB_LEN_W-1:0] PB_LEN_136 = 12'h220;
    localparam logic [PB_LEN_W-1:0] PB_LEN_520 = 12'h820;

    typedef enum logic [1:0] {
        PB_SIZE_16  = 2'b00,
        PB_SIZE_136 = 2'b01,
        PB_SIZE_520 = 2'b10,
        PB_SIZE_ILL = 2'b11
    } pb_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        START = 2'd2,
        DRAIN = 2'd3
    } loader_state_e;

endpackage

// File: rtl/turbo_pb_len_dec.sv
// Combinational decode of the 2-bit PB size select into a length in symbols
// plus an illegal-encoding flag. Shared between the RX and TX sides.
module turbo_pb_len_dec
    import turbo_pkg::*;
(
    input  logic [1:0]          size_sel,
    output logic [PB_LEN_W-1:0] len,
    output logic                illegal
);

    // Map each legal encoding to its length; anything else is flagged.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        len     = '0;
        illegal = 1'b0;
        case (pb_size_e'(size_sel))
            PB_SIZE_16:  len = PB_LEN_16;
            PB_SIZE_136: len = PB_LEN_136;
            PB_SIZE_520: len = PB_LEN_520;
            default:     illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/turbo_rx_pb_loader.sv
// Turbo RX PB loader: fills the deinterleaver RAM with one physical block of
// soft symbols, pulses start, then back-pressures until the reader drains.
// Optional feature macro: TURBO_LOADER_ERR_CNT_EN adds a saturating err_cnt.
module turbo_rx_pb_loader
    import turbo_pkg::*;
#(
    parameter int D_WIDTH   = 2,
    parameter int A_WIDTH   = 12,
    parameter int DRAIN_LAT = 3
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [D_WIDTH-1:0] din,
    input  logic               din_vld,
    input  logic               din_sof,
    output logic               din_rdy,
    input  logic [1:0]         pb_size_sel,
    input  logic [A_WIDTH-1:0] pb_base,
    input  logic               mode_in,
    output logic               wen,
    output logic [A_WIDTH-1:0] waddr,
    output logic [D_WIDTH-1:0] wdata,
    output logic [A_WIDTH-1:0] pb_len,
    output logic [A_WIDTH-1:0] pb_offset,
    output logic               mod_int_dint,
    output logic               start,
    output logic               busy,
    output logic               err
`ifdef TURBO_LOADER_ERR_CNT_EN
    ,
    output logic [7:0]         err_cnt
`endif
);

    loader_state_e       state, next_state;
    logic [A_WIDTH-1:0]  cnt;
    logic [A_WIDTH:0]    drain_cnt;
    logic [A_WIDTH:0]    drain_last;
    logic [A_WIDTH-1:0]  last_idx;
    logic [PB_LEN_W-1:0] dec_len;
    logic                size_illegal;
    logic                sof_ok;
    logic                wr_fill;
    logic                err_set;

    turbo_pb_len_dec u_len_dec (
        .size_sel (pb_size_sel),
        .len      (dec_len),
        .illegal  (size_illegal)
    );

    assign last_idx   = pb_len - A_WIDTH'(1);
    assign drain_last = {1'b0, pb_len} + (A_WIDTH + 1)'(DRAIN_LAT - 1);
    assign busy       = (state != IDLE);

    // State register; async reset discards any partial PB.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, ready and per-symbol decisions (legal SOF, fill write, error).
    always_comb begin
        next_state = state;
        din_rdy    = 1'b0;
        sof_ok     = 1'b0;
        wr_fill    = 1'b0;
        err_set    = 1'b0;
        case (state)
            IDLE: begin
                din_rdy = 1'b1;
                if (din_vld) begin
                    if (!din_sof || size_illegal) begin
                        err_set = 1'b1;
                    end else begin
                        sof_ok     = 1'b1;
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                din_rdy = 1'b1;
                if (din_vld) begin
                    if (din_sof) begin
                        // A new SOF aborts the current PB and restarts.
                        err_set = 1'b1;
                        if (size_illegal) begin
                            next_state = IDLE;
                        end else begin
                            sof_ok = 1'b1;
                        end
                    end else begin
                        wr_fill = 1'b1;
                        if (cnt == last_idx) begin
                            next_state = START;
                        end
                    end
                end
            end
            START:   next_state = DRAIN;
            DRAIN:   if (drain_cnt == drain_last) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Registered write port, PB descriptor latches, counters and pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wen          <= 1'b0;
            waddr        <= '0;
            wdata        <= '0;
            pb_len       <= '0;
            pb_offset    <= '0;
            mod_int_dint <= 1'b0;
            start        <= 1'b0;
            err          <= 1'b0;
            cnt          <= '0;
            drain_cnt    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register here samples pre-edge values regardless of order.
            wen   <= 1'b0;
            err   <= err_set;
            // Start lands one cycle after the final write, which occurs in START.
            start <= (state == START);
            if (sof_ok) begin
                pb_len       <= A_WIDTH'(dec_len);
                pb_offset    <= pb_base;
                mod_int_dint <= mode_in;
                wen          <= 1'b1;
                waddr        <= pb_base;
                wdata        <= din;
                cnt          <= A_WIDTH'(1);
            end else if (wr_fill) begin
                wen   <= 1'b1;
                waddr <= pb_offset + cnt;
                wdata <= din;
                cnt   <= cnt + A_WIDTH'(1);
            end
            if (state == START) begin
                drain_cnt <= '0;
            end else if (state == DRAIN) begin
                drain_cnt <= drain_cnt + (A_WIDTH + 1)'(1);
            end
        end
    end

`ifdef TURBO_LOADER_ERR_CNT_EN
    // Saturating error counter, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            err_cnt <= '0;
        end else if (err_set && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
